multu_hilo: RTL and testbench

Sequential unsigned multiplier and Hi/Lo register pair for the MIPS-Lite pipeline. Executes MULTU with a 32-iteration shift-add algorithm and holds the 64-bit product in Hi/Lo. Sits directly upstream of the writeback result multiplexer, which reads `HiOut` and `LoOut` for MFHI and MFLO. Asserts a stall toward the pipeline while a multiply is in flight.

---
 rtl/multu_hilo.sv | 138 +++++++++++++
 tb/tb_multu_hilo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multu_hilo.sv
// multu_hilo: sequential unsigned shift-add multiplier feeding the Hi/Lo pair.
// A MULTU accepted in IDLE runs WIDTH iterations (one per cycle) and then
// writes the full 2*WIDTH-bit product into Hi/Lo. While the unit is busy it
// stalls only the instructions that depend on it (MULTU, MFHI, MFLO).
module multu_hilo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic [5:0]       sel,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic [WIDTH-1:0] HiOut,
   output logic [WIDTH-1:0] LoOut,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int ACC_W = 2 * WIDTH + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               accept;
   logic [ACC_W-1:0]   acc_step;

   // One shift-add iteration. The conditional add is WIDTH+1 bits wide so
   // the carry out of the upper half lands in the spare top bit, and the
   // following right shift brings it back into the product.
   function automatic logic [ACC_W-1:0] shift_add_step(
      input logic [ACC_W-1:0] acc,
      input logic [WIDTH-1:0] mcand
   );
      logic [WIDTH:0] upper;
      upper = acc[ACC_W-1:WIDTH];
      if (acc[0]) begin
         upper = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
      end
      return {1'b0, upper, acc[WIDTH-1:1]};
   endfunction

   assign accept   = (state_q == IDLE) && valid && (sel == FUNCT_MULTU);
   assign acc_step = shift_add_step(acc_q, mcand_q);

   // Next-state, datapath and Hi/Lo update logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               mcand_d = dataA;
               acc_d   = {{(WIDTH + 1){1'b0}}, dataB};
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               // Final iteration: publish the product and go back to IDLE.
               hi_d    = acc_step[2*WIDTH-1:WIDTH];
               lo_d    = acc_step[WIDTH-1:0];
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RUN);
   end

   // State register; reset aborts any multiply in flight and clears Hi/Lo.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Multiplicand holding register; only meaningful while RUN.
   always_ff @(posedge clk) begin
      mcand_q <= mcand_d;
   end

   assign HiOut = hi_q;
   assign LoOut = lo_q;
   assign busy  = busy_q;
   assign done  = done_q;

   // Only instructions that consume or restart the multiplier wait on it.
   assign stall = busy_q && valid &&
                  ((sel == FUNCT_MULTU) || (sel == FUNCT_MFHI) || (sel == FUNCT_MFLO));

endmodule

// File: tb/tb_multu_hilo.sv
// Testbench for multu_hilo: table of directed products plus hand-written
// sequences for stall, back-to-back, mid-operation reset and idle behaviour.
module tb_multu_hilo;

   localparam logic [5:0] MULTU = 6'b011001;
   localparam logic [5:0] MFHI  = 6'b010000;
   localparam logic [5:0] MFLO  = 6'b010010;
   localparam logic [5:0] ADD   = 6'b100000;

   logic        clk;
   logic        rst;
   logic        valid;
   logic [5:0]  sel;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic [31:0] HiOut;
   logic [31:0] LoOut;
   logic        busy;
   logic        done;
   logic        stall;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[8];

   multu_hilo #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .valid (valid),
      .sel   (sel),
      .dataA (dataA),
      .dataB (dataB),
      .HiOut (HiOut),
      .LoOut (LoOut),
      .busy  (busy),
      .done  (done),
      .stall (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for done; returns number of edges waited.
   task automatic wait_done(output int n, output int busy_low);
      n = 0;
      busy_low = 0;
      while (!done && n < 40) begin
         if (!busy) busy_low++;
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      int bl;
      int done_seen;
      int busy_seen;

      vecs[0] = '{32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F};
      vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
      vecs[2] = '{32'h8000_0000,  32'd2,          32'h0000_0001, 32'h0000_0000};
      vecs[3] = '{32'h1234_5678,  32'h10,         32'h0000_0001, 32'h2345_6780};
      vecs[4] = '{32'd0,          32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0000};
      vecs[5] = '{32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 32'hFFFF_FFFF};
      vecs[6] = '{32'h0001_0000,  32'h0001_0000,  32'h0000_0001, 32'h0000_0000};
      vecs[7] = '{32'd7,          32'd9,          32'h0000_0000, 32'h0000_003F};

      rst = 1'b1; valid = 1'b0; sel = 6'd0; dataA = '0; dataB = '0;
      tick();
      tick();
      chk("rst_hi",    {32'd0, HiOut}, 64'd0);
      chk("rst_lo",    {32'd0, LoOut}, 64'd0);
      chk("rst_busy",  {63'd0, busy},  64'd0);
      chk("rst_done",  {63'd0, done},  64'd0);
      rst = 1'b0;
      tick();

      // Table-driven products.
      for (int i = 0; i < 8; i++) begin
         valid = 1'b1; sel = MULTU; dataA = vecs[i].a; dataB = vecs[i].b;
         tick();                                   // E0
         chk($sformatf("v%0d_busy_e0", i), {63'd0, busy}, 64'd1);
         valid = 1'b0; sel = 6'd0; dataA = '0; dataB = '0;
         wait_done(n, bl);
         chk($sformatf("v%0d_latency", i), n, 64'd32);
         chk($sformatf("v%0d_busy_gap", i), bl, 64'd0);
         chk($sformatf("v%0d_hi", i), {32'd0, HiOut}, {32'd0, vecs[i].hi});
         chk($sformatf("v%0d_lo", i), {32'd0, LoOut}, {32'd0, vecs[i].lo});
         chk($sformatf("v%0d_busy_done", i), {63'd0, busy}, 64'd0);
         tick();                                   // E33
         chk($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
      end

      // Hazard stall: MULTU 7x9 then MFHI held; one ADD while busy.
      valid = 1'b1; sel = MULTU; dataA = 32'd7; dataB = 32'd9;
      tick();                                      // E0
      for (int k = 0; k < 32; k++) begin
         sel = (k == 5) ? ADD : MFHI;
         #1;
         chk($sformatf("stall_c%0d", k), {63'd0, stall}, (k == 5) ? 64'd0 : 64'd1);
         tick();
      end
      sel = MFHI;
      #1;
      chk("stall_done_cycle", {63'd0, stall}, 64'd0);
      chk("stall_done",       {63'd0, done},  64'd1);
      chk("stall_lo",         {32'd0, LoOut}, 64'd63);
      chk("stall_hi",         {32'd0, HiOut}, 64'd0);
      valid = 1'b0; sel = 6'd0;
      tick();

      // No spurious start: ADD with valid, then MULTU without valid.
      busy_seen = 0;
      for (int k = 0; k < 40; k++) begin
         valid = (k < 20); sel = (k < 20) ? ADD : MULTU;
         dataA = 32'hDEAD; dataB = 32'hBEEF;
         tick();
         if (busy || done) busy_seen++;
      end
      chk("idle_busy",   busy_seen, 64'd0);
      chk("idle_hi",     {32'd0, HiOut}, 64'd0);
      chk("idle_lo",     {32'd0, LoOut}, 64'd63);
      valid = 1'b0; sel = 6'd0;

      // Back-to-back: 2x3 then 4x5 held until accepted in the done cycle.
      valid = 1'b1; sel = MULTU; dataA = 32'd2; dataB = 32'd3;
      tick();                                      // E0
      dataA = 32'd4; dataB = 32'd5;
      #1;
      chk("b2b_stall_busy", {63'd0, stall}, 64'd1);
      wait_done(n, bl);
      chk("b2b_lat1",  n, 64'd32);
      chk("b2b_lo1",   {32'd0, LoOut}, 64'd6);
      chk("b2b_stall_done", {63'd0, stall}, 64'd0);
      tick();                                      // E33: second accepted
      chk("b2b_busy_e33", {63'd0, busy}, 64'd1);
      chk("b2b_lo_e33",   {32'd0, LoOut}, 64'd6);
      valid = 1'b0; sel = 6'd0;
      n = 0;
      bl = 0;
      while (!done && n < 40) begin
         if (LoOut != 32'd6 || HiOut != 32'd0) bl++;
         tick();
         n++;
      end
      chk("b2b_hold",  bl, 64'd0);
      chk("b2b_lat2",  n, 64'd32);
      chk("b2b_hi2",   {32'd0, HiOut}, 64'd0);
      chk("b2b_lo2",   {32'd0, LoOut}, 64'd20);
      tick();

      // Reset mid-operation at E10.
      valid = 1'b1; sel = MULTU; dataA = 32'h1234; dataB = 32'h10;
      tick();                                      // E0
      valid = 1'b0; sel = 6'd0;
      repeat (9) tick();                           // after E9
      chk("rmid_busy_pre", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      tick();                                      // E10
      chk("rmid_busy", {63'd0, busy},  64'd0);
      chk("rmid_hi",   {32'd0, HiOut}, 64'd0);
      chk("rmid_lo",   {32'd0, LoOut}, 64'd0);
      chk("rmid_done", {63'd0, done},  64'd0);
      rst = 1'b0;
      done_seen = 0;
      busy_seen = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (done) done_seen++;
         if (busy) busy_seen++;
      end
      chk("rmid_no_done", done_seen, 64'd0);
      chk("rmid_no_busy", busy_seen, 64'd0);
      chk("rmid_lo_after", {32'd0, LoOut}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
